hd_beat_timer: RTL and testbench
================================

// Module: hd_beat_timer
// PURPOSE
//  Beat/phase timing generator feeding the hardwired controller. Produces the
//  one-hot beat vector W[3:1] and the per-beat phase strobes T[3:1], which
//  include the T3 the controller latches on. Consumes the controller's
//  STOP/SHORT/LONG outputs to size each instruction (1, 2 or 3 beats) and to
//  pause the machine. The panel start key QD resumes a paused machine.
// PARAMETERS
//  QD_SYNC  2  flip-flop stages synchronising the asynchronous QD key (>=2)
// PORTS
//  CLK    in   1  system clock; all state changes on rising edge
//  CLR    in   1  asynchronous, active-low reset (same CLR the controller uses)
//  QD     in   1  asynchronous start/continue key, active-high level
//  SSTEP  in   1  single-beat mode: pause after every beat
//  STOP   in   1  from controller: pause after current beat completes
//  SHORT  in   1  from controller: current instruction is W1 only
//  LONG   in   1  from controller: current instruction adds W3
//  W      out  3  one-hot beat W[3:1]; exactly one bit set at all times
//  T      out  3  one-hot phase T[3:1] while running; 3'b000 while paused
//  T3     out  1  equals T[3]; one CLK wide
//  RUN    out  1  1 while phases advance, 0 while paused
// BEHAVIOUR
//  - Reset (CLR=0, async): W=3'b001, T=3'b000, RUN=0, QD sync chain=0,
//    edge-detect register=0. State PAUSE.
//  - States: PAUSE, RUN. In RUN, phase cycles T1->T2->T3->T1; each phase is
//    one CLK. One beat is therefore 3 CLK.
//  - Beat decisions happen on the CLK edge ending T3. STOP/SHORT/LONG/SSTEP
//    are sampled only at that edge; their values in T1/T2 are ignored.
//  - Next beat from W1: W1 if SHORT, else W2. From W2: W3 if LONG, else W1.
//    From W3: W1. SHORT has priority over LONG. LONG during W1 is ignored.
//  - Pause: if STOP|SSTEP at the end of T3, W advances to the next beat as
//    above, T->000, RUN->0, state->PAUSE. The controller therefore sees the
//    next beat's W with no T3 and makes no state change.
//  - Resume: a rising edge of synchronised QD while in PAUSE -> state RUN,
//    T=001 on the following CLK. W is unchanged. Latency is QD_SYNC+1 CLK
//    from a QD rise to T1.
//  - QD held high does not retrigger; only a 0->1 edge starts the timer.
//    QD edges during RUN are discarded and are not queued.
//  - After reset the machine stays in PAUSE with W1 presented until the
//    first QD edge.
//  - CLR low mid-beat: immediate return to the reset values. No partial
//    beat completes.
//  - No output is X after reset. W is never 000 or multi-hot; an illegal
//    internal encoding recovers to W1, T=000, PAUSE on the next CLK.
//  - T3 is registered, with no combinational path from the inputs.
// TESTING
//  1 Reset, QD pulse, SHORT=LONG=STOP=0 -> W: 001x3,010x3,001x3... CLK;
//    T3 high on CLK 3,6,9 after the start.
//  2 SHORT=1 held -> W stays 001; T3 every 3 CLK; W2 never asserted.
//  3 LONG=1 with SHORT=0 -> W sequence 001,010,100,001, 3 CLK each; with
//    SHORT=LONG=1 -> W stays 001.
//  4 STOP=1 at W1/T3 -> W=010, T=000, RUN=0 held 20 CLK; QD edge -> T=001
//    after QD_SYNC+1 CLK; QD held 50 CLK -> only one resume.
//  5 SSTEP=1 -> exactly one beat (3 T pulses) per QD edge; QD edges during
//    RUN are ignored.
//  6 CLR=0 asynchronously at W2/T2 -> W=001, T=000, RUN=0 immediately,
//    with no T3 emitted.

Source files
------------

// File: rtl/hd_beat_timer.sv
// Beat/phase timing generator: one-hot beat W[3:1] and phase T[3:1] for the hardwired controller.
// Latency: a phase advances every CLK while running; a QD rise reaches T1 after QD_SYNC+1 CLK.
// No backpressure: STOP/SSTEP pause at the end of a beat, and only a fresh QD rise resumes.
module hd_beat_timer #(
   parameter int QD_SYNC = 2
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       QD,
   input  logic       SSTEP,
   input  logic       STOP,
   input  logic       SHORT,
   input  logic       LONG,
   output logic [3:1] W,
   output logic [3:1] T,
   output logic       T3,
   output logic       RUN
);

   typedef enum logic {
      S_PAUSE = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t             state_q;
   logic [3:1]         w_q;
   logic [3:1]         w_d;
   logic [3:1]         t_q;
   logic               run_q;
   logic [QD_SYNC-1:0] qd_sync_q;
   logic               qd_edge_q;
   logic               qd_rise;
   logic               w_ok;
   logic               t_ok;
   logic               legal;

   // Synchronise the asynchronous start key and remember its previous synchronised level.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         qd_sync_q <= '0;
         qd_edge_q <= 1'b0;
      end else begin
         qd_sync_q <= {qd_sync_q[QD_SYNC-2:0], QD};
         qd_edge_q <= qd_sync_q[QD_SYNC-1];
      end
   end

   // A held key yields a single pulse; rises seen while running are simply dropped.
   assign qd_rise = qd_sync_q[QD_SYNC-1] & ~qd_edge_q;

   // Beat that follows the current one; SHORT outranks LONG, and LONG only matters in W2.
   always_comb begin
      w_d = 3'b001;
      case (w_q)
         3'b001:  w_d = SHORT ? 3'b001 : 3'b010;
         3'b010:  w_d = LONG  ? 3'b100 : 3'b001;
         default: w_d = 3'b001;
      endcase
   end

   // Detect any corrupted encoding so the machine can fall back to a clean paused W1.
   always_comb begin
      w_ok  = (w_q == 3'b001) || (w_q == 3'b010) || (w_q == 3'b100);
      t_ok  = (state_q == S_RUN) ? ((t_q == 3'b001) || (t_q == 3'b010) || (t_q == 3'b100))
                                 : (t_q == 3'b000);
      legal = w_ok && t_ok && (run_q == (state_q == S_RUN));
   end

   // Pause/run sequencer; all outputs come straight from these registers.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= S_PAUSE;
         w_q     <= 3'b001;
         t_q     <= 3'b000;
         run_q   <= 1'b0;
      end else if (!legal) begin
         state_q <= S_PAUSE;
         w_q     <= 3'b001;
         t_q     <= 3'b000;
         run_q   <= 1'b0;
      end else begin
         case (state_q)
            S_PAUSE: begin
               if (qd_rise) begin
                  state_q <= S_RUN;
                  t_q     <= 3'b001;
                  run_q   <= 1'b1;
               end
            end
            S_RUN: begin
               case (t_q)
                  3'b001: t_q <= 3'b010;
                  3'b010: t_q <= 3'b100;
                  default: begin
                     // End of T3: the only point where the beat and pause decisions are taken.
                     w_q <= w_d;
                     if (STOP || SSTEP) begin
                        state_q <= S_PAUSE;
                        t_q     <= 3'b000;
                        run_q   <= 1'b0;
                     end else begin
                        t_q <= 3'b001;
                     end
                  end
               endcase
            end
            default: begin
               state_q <= S_PAUSE;
               w_q     <= 3'b001;
               t_q     <= 3'b000;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign W   = w_q;
   assign T   = t_q;
   assign T3  = t_q[3];
   assign RUN = run_q;

endmodule

// File: tb/tb_hd_beat_timer.sv
// Directed and randomized bench for hd_beat_timer against a beat/phase counting model.
// Latency: outputs are checked 1 time unit after every rising CLK edge.
// Backpressure: none; STOP/SSTEP/QD are driven between edges.
module tb_hd_beat_timer;

   localparam int QD_SYNC = 2;

   logic       CLK = 1'b0;
   logic       CLR;
   logic       QD;
   logic       SSTEP;
   logic       STOP;
   logic       SHORT;
   logic       LONG;
   logic [3:1] W;
   logic [3:1] T;
   logic       T3;
   logic       RUN;

   int checks   = 0;
   int failures = 0;

   // Reference model: running flag, phase number 1..3, beat number 1..3, sampled QD history.
   bit  m_run;
   int  m_phase;
   int  m_beat;
   bit  qh[$];

   hd_beat_timer #(.QD_SYNC(QD_SYNC)) dut (
      .CLK   (CLK),
      .CLR   (CLR),
      .QD    (QD),
      .SSTEP (SSTEP),
      .STOP  (STOP),
      .SHORT (SHORT),
      .LONG  (LONG),
      .W     (W),
      .T     (T),
      .T3    (T3),
      .RUN   (RUN)
   );

   always #5 CLK = ~CLK;

   function automatic bit hist(int k);
      if (k < qh.size()) return qh[k];
      return 1'b0;
   endfunction

   function automatic logic [2:0] one_hot(int n);
      logic [2:0] v;
      v = 3'b001 << (n - 1);
      return v;
   endfunction

   task automatic model_reset();
      m_run   = 1'b0;
      m_phase = 1;
      m_beat  = 1;
      qh.delete();
   endtask

   // One rising edge of the specified behaviour, using the inputs present at that edge.
   task automatic model_step();
      bit rise;
      qh.push_front(QD);
      if (qh.size() > 8) void'(qh.pop_back());
      // A QD level first sampled at edge j is seen as a rise at edge j+QD_SYNC.
      rise = hist(QD_SYNC) && !hist(QD_SYNC + 1);
      if (m_run) begin
         if (m_phase < 3) begin
            m_phase = m_phase + 1;
         end else begin
            if (m_beat == 1)      m_beat = SHORT ? 1 : 2;
            else if (m_beat == 2) m_beat = LONG ? 3 : 1;
            else                  m_beat = 1;
            if (STOP || SSTEP) m_run = 1'b0;
            else               m_phase = 1;
         end
      end else if (rise) begin
         m_run   = 1'b1;
         m_phase = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [2:0] exp_t;
      exp_t = m_run ? one_hot(m_phase) : 3'b000;
      chk({tag, ".W"},   {29'd0, W},   {29'd0, one_hot(m_beat)});
      chk({tag, ".T"},   {29'd0, T},   {29'd0, exp_t});
      chk({tag, ".T3"},  {31'd0, T3},  {31'd0, exp_t[2]});
      chk({tag, ".RUN"}, {31'd0, RUN}, {31'd0, m_run});
      chk({tag, ".W_onehot"}, {31'd0, $onehot(W)}, 32'd1);
   endtask

   task automatic tick(input string tag);
      @(posedge CLK);
      if (CLR) model_step();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset applied between edges, checked immediately, released after one edge.
   task automatic do_reset(input string tag);
      CLR = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      tick(tag);
      CLR = 1'b1;
   endtask

   // One-edge QD pulse; returns with T1 presented.
   task automatic start(input string tag);
      QD = 1'b1;
      tick(tag);
      QD = 1'b0;
      tick(tag);
      tick(tag);
   endtask

   initial begin
      int cnt;
      int n;
      bit seen;
      logic prev_run;

      CLR = 1'b1; QD = 1'b0; SSTEP = 1'b0; STOP = 1'b0; SHORT = 1'b0; LONG = 1'b0;
      model_reset();
      #2;
      CLR = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      chk("reset_W", {29'd0, W}, 32'd1);
      chk("reset_T", {29'd0, T}, 32'd0);
      tick("reset");
      CLR = 1'b1;
      repeat (4) tick("idle");
      chk("idle_RUN", {31'd0, RUN}, 32'd0);

      // Basic W1/W2 alternation; T3 every third CLK.
      QD = 1'b1;
      tick("t1");
      QD = 1'b0;
      cnt = 0;
      for (int i = 0; i < 14; i++) begin
         tick("t1");
         if (T3) cnt++;
      end
      chk("t1_t3_count", cnt, 4);

      // SHORT held: W2 never appears.
      do_reset("t2_rst");
      SHORT = 1'b1;
      start("t2");
      seen = 1'b0; cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick("t2");
         if (W[2]) seen = 1'b1;
         if (T3) cnt++;
      end
      chk("t2_w2_seen", {31'd0, seen}, 32'd0);
      chk("t2_t3_count", cnt, 4);
      SHORT = 1'b0;

      // LONG: W1, W2, W3, W1; then SHORT+LONG keeps W1.
      do_reset("t3_rst");
      LONG = 1'b1;
      start("t3");
      for (int i = 1; i <= 9; i++) begin
         tick("t3");
         if (i == 3) chk("t3_w2", {29'd0, W}, 32'd2);
         if (i == 6) chk("t3_w3", {29'd0, W}, 32'd4);
         if (i == 9) chk("t3_w1", {29'd0, W}, 32'd1);
      end
      SHORT = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick("t3b");
         if (W != 3'b001) seen = 1'b1;
      end
      chk("t3_short_long_w1", {31'd0, seen}, 32'd0);
      SHORT = 1'b0; LONG = 1'b0;

      // STOP at W1/T3, long pause, resume latency, held QD resumes once.
      do_reset("t4_rst");
      start("t4");
      STOP = 1'b1;
      repeat (3) tick("t4");
      STOP = 1'b0;
      chk("t4_pause_W", {29'd0, W}, 32'd2);
      chk("t4_pause_T", {29'd0, T}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick("t4_hold");
         if (RUN || T != 3'b000) cnt++;
      end
      chk("t4_hold_active", cnt, 0);
      QD = 1'b1;
      n = 0;
      do begin
         tick("t4_resume");
         n++;
      end while (T != 3'b001 && n < 10);
      chk("t4_resume_latency", n, QD_SYNC + 1);
      STOP = 1'b1;
      cnt = 0;
      prev_run = RUN;
      for (int i = 0; i < 50; i++) begin
         tick("t4_qd_held");
         if (RUN && !prev_run) cnt++;
         prev_run = RUN;
      end
      chk("t4_extra_resumes", cnt, 0);
      chk("t4_end_RUN", {31'd0, RUN}, 32'd0);
      QD = 1'b0; STOP = 1'b0;

      // SSTEP: one beat per QD edge; a QD pulse during the beat is discarded.
      do_reset("t5_rst");
      SSTEP = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cnt = 0;
         for (int i = 1; i <= 15; i++) begin
            QD = (i == 1 || i == 4);
            tick("t5");
            if (T != 3'b000) cnt++;
         end
         QD = 1'b0;
         chk("t5_phases_per_edge", cnt, 3);
         chk("t5_W_after", {29'd0, W}, (k == 0) ? 32'd2 : 32'd1);
      end
      SSTEP = 1'b0;

      // Asynchronous clear at W2/T2: immediate reset values, no T3.
      do_reset("t6_rst");
      start("t6");
      n = 0;
      while (!(W == 3'b010 && T == 3'b010) && n < 20) begin
         tick("t6_seek");
         n++;
      end
      chk("t6_reached_w2t2", n, 4);
      #2;
      CLR = 1'b0;
      #1;
      model_reset();
      check_all("t6_clr");
      chk("t6_W", {29'd0, W}, 32'd1);
      chk("t6_RUN", {31'd0, RUN}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("t6_held");
         if (T3) seen = 1'b1;
      end
      chk("t6_no_t3", {31'd0, seen}, 32'd0);
      CLR = 1'b1;

      // Randomized traffic against the model, with occasional asynchronous clears.
      for (int i = 0; i < 800; i++) begin
         QD    = ($urandom_range(0, 3) == 0);
         STOP  = ($urandom_range(0, 5) == 0);
         SSTEP = ($urandom_range(0, 7) == 0);
         SHORT = $urandom_range(0, 1);
         LONG  = $urandom_range(0, 1);
         if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
         else tick("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
